bcd_display_driver: RTL and testbench

//  Downstream peripheral stage of the stack CPU. Captures the CPU's 8-bit unsigned output word
//  and converts it to BCD with a sequential double-dabble engine (one shift per clock).

---
 rtl/bcd_display_driver.sv | 241 ++++++++++++++++++++++++
 tb/tb_bcd_display_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver.sv
// -----------------------------------------------------------------------------
// bcd_display_driver
//
// Downstream peripheral stage of the stack CPU. Captures the CPU's unsigned
// output word, converts it to BCD with a sequential double-dabble engine (one
// shift per clock), and drives three registered 7-segment digits
// (hundreds / tens / ones). While the CPU error line is high all three digits
// show "Err". The conversion keeps running underneath, so its result is not
// lost.
//
// Parameters
//   DATA_WIDTH      width of the unsigned input value (1..9; 511 fits 3 digits)
//   SEG_ACTIVE_LOW  0: segment lit = 1; 1: all segment outputs inverted
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, a zero hundreds digit is blanked, and
//                          the tens digit is blanked when hundreds and tens are
//                          both zero. The ones digit is always shown, and the
//                          error pattern is never blanked.
//                          Undefined (default): all three digits always shown.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   in             in   [DATA_WIDTH] unsigned value from the CPU
//   in_valid       in   1-cycle strobe, in is new
//   error          in   CPU error level
//   busy           out  conversion in progress
//   done           out  1-cycle pulse, digits just updated from a conversion
//   ones_7seg      out  [7] {g,f,e,d,c,b,a}, bit0 = a
//   tens_7seg      out  [7] same encoding
//   hundreds_7seg  out  [7] same encoding
// -----------------------------------------------------------------------------
module bcd_display_driver #(
   parameter int DATA_WIDTH     = 8,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  in_valid,
   input  logic                  error,
   output logic                  busy,
   output logic                  done,
   output logic [6:0]            ones_7seg,
   output logic [6:0]            tens_7seg,
   output logic [6:0]            hundreds_7seg
);

   // Scratch layout: {hundreds, tens, ones, binary}. The binary field is
   // exactly DATA_WIDTH wide, so DATA_WIDTH shifts move every input bit into
   // the BCD field.
   localparam int         SCR_W      = 12 + DATA_WIDTH;
   localparam logic [3:0] LAST_SHIFT = 4'(DATA_WIDTH - 1);

   localparam logic [6:0] SEG_ZERO  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b1111001;
   localparam logic [6:0] SEG_R     = 7'b1010000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_POL   = {7{SEG_ACTIVE_LOW}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [SCR_W-1:0]      scratch_q, scratch_d;
   logic [DATA_WIDTH-1:0] pend_val_q, pend_val_d;
   logic                  pend_q, pend_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [3:0]            dig_h_q, dig_h_d;
   logic [3:0]            dig_t_q, dig_t_d;
   logic [3:0]            dig_o_q, dig_o_d;
   logic [6:0]            seg_h_q, seg_h_d;
   logic [6:0]            seg_t_q, seg_t_d;
   logic [6:0]            seg_o_q, seg_o_d;
   logic [6:0]            pat_h, pat_t, pat_o;

   // 7-segment pattern for one BCD digit, {g,f,e,d,c,b,a}. Codes above 9
   // cannot come out of the converter and are shown dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0111111;
         4'd1:    p = 7'b0000110;
         4'd2:    p = 7'b1011011;
         4'd3:    p = 7'b1001111;
         4'd4:    p = 7'b1100110;
         4'd5:    p = 7'b1101101;
         4'd6:    p = 7'b1111101;
         4'd7:    p = 7'b0000111;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
   // the whole scratch left by one bit.
   function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] s);
      logic [11:0]      bcd;
      logic [SCR_W-1:0] adj;
      bcd = s[SCR_W-1 -: 12];
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            bcd[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
      adj = {bcd, s[DATA_WIDTH-1:0]};
      return {adj[SCR_W-2:0], 1'b0};
   endfunction

   // Conversion FSM and pending-value capture
   always_comb begin
      state_d    = state_q;
      scratch_d  = scratch_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      cnt_d      = cnt_q;
      dig_h_d    = dig_h_q;
      dig_t_d    = dig_t_q;
      dig_o_d    = dig_o_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A fresh strobe beats a stored value; the stored one is stale.
            if (in_valid) begin
               scratch_d = {12'b0, in};
               cnt_d     = 4'd0;
               pend_d    = 1'b0;
               state_d   = ST_SHIFT;
            end else if (pend_q) begin
               scratch_d = {12'b0, pend_val_q};
               cnt_d     = 4'd0;
               pend_d    = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            scratch_d = dabble_step(scratch_q);
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == LAST_SHIFT) begin
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            dig_h_d = scratch_q[SCR_W-1 -: 4];
            dig_t_d = scratch_q[SCR_W-5 -: 4];
            dig_o_d = scratch_q[SCR_W-9 -: 4];
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes arriving while the engine is occupied go to the single-entry
      // pending slot; the newest value wins.
      if (in_valid && (state_q != ST_IDLE)) begin
         pend_val_d = in;
         pend_d     = 1'b1;
      end

      // busy is registered from the next state, so it drops on the edge that
      // enters IDLE and rises on the edge that starts a conversion.
      busy_d = (state_d != ST_IDLE);
   end

   // Segment pattern selection. Decoding the next-state digits lets the
   // segments change on the same edge that writes the digit registers.
   always_comb begin
      pat_h = seg_decode(dig_h_d);
      pat_t = seg_decode(dig_t_d);
      pat_o = seg_decode(dig_o_d);
`ifdef LEADING_ZERO_BLANK_EN
      if (dig_h_d == 4'd0) begin
         pat_h = SEG_BLANK;
         if (dig_t_d == 4'd0) begin
            pat_t = SEG_BLANK;
         end
      end
`else
      // All three digits are always shown, leading zeros included.
`endif
      if (error) begin
         pat_h = SEG_E;
         pat_t = SEG_R;
         pat_o = SEG_R;
      end
      seg_h_d = pat_h ^ SEG_POL;
      seg_t_d = pat_t ^ SEG_POL;
      seg_o_d = pat_o ^ SEG_POL;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         scratch_q  <= '0;
         pend_val_q <= '0;
         pend_q     <= 1'b0;
         cnt_q      <= 4'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dig_h_q    <= 4'd0;
         dig_t_q    <= 4'd0;
         dig_o_q    <= 4'd0;
         seg_h_q    <= SEG_ZERO ^ SEG_POL;
         seg_t_q    <= SEG_ZERO ^ SEG_POL;
         seg_o_q    <= SEG_ZERO ^ SEG_POL;
      end else begin
         state_q    <= state_d;
         scratch_q  <= scratch_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dig_h_q    <= dig_h_d;
         dig_t_q    <= dig_t_d;
         dig_o_q    <= dig_o_d;
         seg_h_q    <= seg_h_d;
         seg_t_q    <= seg_t_d;
         seg_o_q    <= seg_o_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign hundreds_7seg = seg_h_q;
   assign tens_7seg     = seg_t_q;
   assign ones_7seg     = seg_o_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_driver
//
// Directed bench for bcd_display_driver (DATA_WIDTH=8, active-high segments).
// Expected segment patterns are written out by hand from the digit table.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_bcd_display_driver;

   localparam logic [6:0] S0 = 7'b0111111;
   localparam logic [6:0] S1 = 7'b0000110;
   localparam logic [6:0] S2 = 7'b1011011;
   localparam logic [6:0] S3 = 7'b1001111;
   localparam logic [6:0] S5 = 7'b1101101;
   localparam logic [6:0] S7 = 7'b0000111;
   localparam logic [6:0] SE = 7'b1111001;
   localparam logic [6:0] SR = 7'b1010000;
   localparam logic [6:0] SB = 7'b0000000;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [20:0] EXP_IDLE = {SB, SB, S0};
   localparam logic [20:0] EXP_7    = {SB, SB, S7};
   localparam logic [20:0] EXP_30   = {SB, S3, S0};
`else
   localparam logic [20:0] EXP_IDLE = {S0, S0, S0};
   localparam logic [20:0] EXP_7    = {S0, S0, S7};
   localparam logic [20:0] EXP_30   = {S0, S3, S0};
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_v;
   logic       in_valid;
   logic       error;
   logic       busy;
   logic       done;
   logic [6:0] ones_7seg;
   logic [6:0] tens_7seg;
   logic [6:0] hundreds_7seg;
   logic [20:0] segs;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   int pulses;

   bcd_display_driver #(
      .DATA_WIDTH     (8),
      .SEG_ACTIVE_LOW (1'b0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in            (in_v),
      .in_valid      (in_valid),
      .error         (error),
      .busy          (busy),
      .done          (done),
      .ones_7seg     (ones_7seg),
      .tens_7seg     (tens_7seg),
      .hundreds_7seg (hundreds_7seg)
   );

   always #5 clk = ~clk;

   assign segs = {hundreds_7seg, tens_7seg, ones_7seg};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] v);
      in_v     = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Advance until done is seen, returning the number of edges taken.
   // Gives up after 40 edges; the caller's latency check then fails.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 40);
   endtask

   task automatic count_done(input int edges, output int n);
      n = 0;
      for (int i = 0; i < edges; i++) begin
         tick();
         if (done) n++;
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_v     = 8'd0;
      in_valid = 1'b0;
      error    = 1'b0;

      // Reset held for two edges
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_segs", 32'(segs), 32'({S0, S0, S0}));
      reset = 1'b0;
      tick();
      check("idle_segs", 32'(segs), 32'(EXP_IDLE));
      check("idle_busy", 32'(busy), 32'd0);

      // 233: nine-cycle latency, single done pulse
      strobe(8'hE9);
      check("233_busy", 32'(busy), 32'd1);
      wait_done(cyc);
      check("233_lat", 32'(cyc), 32'd9);
      check("233_segs", 32'(segs), 32'({S2, S3, S3}));
      check("233_busy_end", 32'(busy), 32'd0);
      tick();
      check("233_done_width", 32'(done), 32'd0);

      // 255, then 7 strobed three cycles later while busy
      strobe(8'd255);
      tick();
      tick();
      strobe(8'd7);
      wait_done(cyc);
      check("255_lat", 32'(cyc), 32'd6);
      check("255_segs", 32'(segs), 32'({S2, S5, S5}));
      check("255_busy_gap", 32'(busy), 32'd0);
      tick();
      check("7_restart_busy", 32'(busy), 32'd1);
      wait_done(cyc);
      check("7_lat", 32'(cyc), 32'd9);
      check("7_segs", 32'(segs), 32'(EXP_7));

      // 200, then 10/20/30 during the same busy window: newest wins
      strobe(8'd200);
      tick();
      strobe(8'd10);
      tick();
      strobe(8'd20);
      strobe(8'd30);
      wait_done(cyc);
      check("200_lat", 32'(cyc), 32'd4);
      check("200_segs", 32'(segs), 32'({S2, S0, S0}));
      tick();
      wait_done(cyc);
      check("30_lat", 32'(cyc), 32'd9);
      check("30_segs", 32'(segs), 32'(EXP_30));
      count_done(20, pulses);
      check("30_no_extra_done", 32'(pulses), 32'd0);

      // Error raised in the middle of converting 150
      strobe(8'd150);
      tick();
      tick();
      error = 1'b1;
      tick();
      check("err_segs", 32'(segs), 32'({SE, SR, SR}));
      check("err_busy", 32'(busy), 32'd1);
      wait_done(cyc);
      check("150_lat", 32'(cyc), 32'd6);
      check("err_hold_segs", 32'(segs), 32'({SE, SR, SR}));
      error = 1'b0;
      tick();
      check("150_segs", 32'(segs), 32'({S1, S5, S0}));

      // Reset during the 4th shift cycle, with a value waiting in pending
      strobe(8'd123);
      tick();
      strobe(8'd45);
      tick();
      reset = 1'b1;
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_segs", 32'(segs), 32'({S0, S0, S0}));
      reset = 1'b0;
      count_done(20, pulses);
      check("abort_no_done", 32'(pulses), 32'd0);
      check("abort_pend_busy", 32'(busy), 32'd0);
      check("abort_idle_segs", 32'(segs), 32'(EXP_IDLE));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
